// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive core: FSM encodings, synchronizer depth, default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int SYNC_DEPTH         = 2;
    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous single-bit input.
// Latency: DEPTH i_clk cycles from i_d to o_q.
// Backpressure: none; free-running.
//
// Ports:
//   i_clk   - system clock
//   i_rst_n - asynchronous active-low reset (all flops clear to 0)
//   i_d     - asynchronous input
//   o_q     - synchronized output
module spi_sync
    import spi_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/spi_rx_core.sv
// SPI frame receiver: oversamples sck/mosi/frame on i_clk and shifts mosi in MSB first.
// Latency: o_valid rises 3 i_clk edges after the i_frame fall is first sampled.
// Backpressure: none; o_valid is a single-cycle pulse that the consumer must take.
//
// Optional feature: define SPI_RX_LEN_CHECK_EN to compare the received bit count
// against i_data_length (sampled at frame rise, 0 treated as 1) and report o_len_err.
//
// Ports:
//   i_clk, i_rst_n   - system clock, asynchronous active-low reset
//   i_sck, i_mosi    - serial clock (idle low) and data, asynchronous to i_clk
//   i_frame          - active-high frame enable
//   i_data_length    - expected bit count (length check build only)
//   o_data           - received word, right-justified
//   o_bit_count      - number of bits held in o_data
//   o_valid          - one-cycle pulse qualifying o_data/o_bit_count/o_overflow/o_len_err
//   o_busy           - high while a frame is being received
//   o_overflow       - frame carried more than DATA_WIDTH bits
//   o_len_err        - bit count differs from expected length
module spi_rx_core
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sck,
    input  logic                  i_mosi,
    input  logic                  i_frame,
    input  logic [3:0]            i_data_length,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CNT_WIDTH-1:0]  o_bit_count,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic                  o_len_err
);

    localparam logic [CNT_WIDTH-1:0] C_MAX     = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [1:0]           WARM_DONE = 2'(SYNC_DEPTH);

    logic w_sck_s;
    logic w_mosi_s;
    logic w_frame_s;

    spi_sync u_sync_sck   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sck),   .o_q(w_sck_s));
    spi_sync u_sync_mosi  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_mosi),  .o_q(w_mosi_s));
    spi_sync u_sync_frame (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_frame), .o_q(w_frame_s));

    state_t                  r_state;
    logic                    r_sck_d;
    logic                    r_frame_d;
    logic [1:0]              r_warm;
    logic                    r_frame_armed;
    logic                    r_rise_pend;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_ovf;

    logic                    w_sck_rise;
    logic                    w_frame_rise;
    logic                    w_frame_fall;
    logic [DATA_WIDTH-1:0]   w_shift_nxt;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;
    logic                    w_ovf_nxt;
    logic                    w_len_err_nxt;

    // The synchronizers come out of reset reading 0, so a frame that is already
    // high would look like a fresh rise. Rise detection is only armed once the
    // synchronizer pipeline has refilled and frame has genuinely been seen low.
    assign w_sck_rise   = w_sck_s & ~r_sck_d;
    assign w_frame_rise = w_frame_s & ~r_frame_d & r_frame_armed;
    assign w_frame_fall = ~w_frame_s & r_frame_d;

    // Next shift/count values; used both for state update and for the output
    // capture, so an sck rise coinciding with the frame fall is still counted.
    always_comb begin
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        if (w_sck_rise) begin
            if (r_cnt == C_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_shift_nxt = {r_shift[DATA_WIDTH-2:0], w_mosi_s};
                w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
            end
        end
    end

`ifdef SPI_RX_LEN_CHECK_EN
    logic [CNT_WIDTH-1:0] r_exp_len;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exp_len <= '0;
        end else if (w_frame_rise) begin
            r_exp_len <= (i_data_length == 4'd0) ? CNT_WIDTH'(1) : CNT_WIDTH'(i_data_length);
        end
    end

    assign w_len_err_nxt = (w_cnt_nxt != r_exp_len);
`else
    logic w_unused_len;
    assign w_unused_len  = ^i_data_length;
    assign w_len_err_nxt = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_sck_d       <= 1'b0;
            r_frame_d     <= 1'b0;
            r_warm        <= '0;
            r_frame_armed <= 1'b0;
            r_rise_pend   <= 1'b0;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_ovf         <= 1'b0;
            o_data        <= '0;
            o_bit_count   <= '0;
            o_valid       <= 1'b0;
            o_busy        <= 1'b0;
            o_overflow    <= 1'b0;
            o_len_err     <= 1'b0;
        end else begin
            r_sck_d   <= w_sck_s;
            r_frame_d <= w_frame_s;
            if (r_warm != WARM_DONE) begin
                r_warm <= r_warm + 2'd1;
            end else if (!w_frame_s) begin
                r_frame_armed <= 1'b1;
            end
            o_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_frame_rise || r_rise_pend) begin
                        r_state     <= ST_RECEIVE;
                        r_shift     <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_rise_pend <= 1'b0;
                        o_busy      <= 1'b1;
                    end
                end
                ST_RECEIVE: begin
                    r_shift <= w_shift_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_ovf   <= w_ovf_nxt;
                    if (w_frame_fall) begin
                        o_busy <= 1'b0;
                        if (w_cnt_nxt != '0) begin
                            r_state     <= ST_DONE;
                            o_data      <= w_shift_nxt;
                            o_bit_count <= w_cnt_nxt;
                            o_overflow  <= w_ovf_nxt;
                            o_len_err   <= w_len_err_nxt;
                            o_valid     <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    // A new frame may open while the result is being presented;
                    // remember it so IDLE can start the next frame immediately.
                    r_state <= ST_IDLE;
                    if (w_frame_rise) begin
                        r_rise_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rx_core.sv
// Testbench for spi_rx_core: randomized SPI frames checked against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_rx_core;

    localparam int DW = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sck = 1'b0;
    logic          mosi = 1'b0;
    logic          frame = 1'b0;
    logic [3:0]    dlen = 4'd0;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_bit_count;
    logic          o_valid;
    logic          o_busy;
    logic          o_overflow;
    logic          o_len_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
        logic          ovf;
        logic          lerr;
    } res_t;

    res_t cap_q[$];

    spi_rx_core #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sck         (sck),
        .i_mosi        (mosi),
        .i_frame       (frame),
        .i_data_length (dlen),
        .o_data        (o_data),
        .o_bit_count   (o_bit_count),
        .o_valid       (o_valid),
        .o_busy        (o_busy),
        .o_overflow    (o_overflow),
        .o_len_err     (o_len_err)
    );

    always #5 clk = ~clk;

    // Every cycle o_valid is high is captured, so a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (o_valid) cap_q.push_back(res_t'({o_data, o_bit_count, o_overflow, o_len_err}));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: the receiver keeps the first min(n,DW) bits, right-justified.
    function automatic res_t model(input logic [63:0] val, input int n, input logic [3:0] len);
        res_t r;
        int c;
        logic [63:0] v;
        c = (n > DW) ? DW : n;
        v = (val >> (n - c)) & ((64'd1 << c) - 64'd1);
        r.data = v[DW-1:0];
        r.cnt  = CW'(c);
        r.ovf  = (n > DW);
`ifdef SPI_RX_LEN_CHECK_EN
        r.lerr = (c != ((len == 4'd0) ? 1 : int'(len)));
`else
        r.lerr = 1'b0;
`endif
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_open(input logic [3:0] len);
        dlen  = len;
        frame = 1'b1;
        tick(3);
    endtask

    task automatic send_bits(input logic [63:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = val[n-1-i];
            tick(2);
            sck = 1'b1;
            tick(2);
            sck = 1'b0;
            tick(2 + int'($urandom_range(0, 1)));
        end
    endtask

    task automatic wait_cap(input int n, input int budget);
        int k;
        k = 0;
        while (cap_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        tick(3);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        checks++; if (o_data !== '0)      begin errors++; $display("FAIL reset_data got %h exp 0", o_data); end
        checks++; if (o_bit_count !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", o_bit_count); end
        checks++; if (o_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        checks++; if (o_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", o_overflow); end
        checks++; if (o_len_err !== 1'b0) begin errors++; $display("FAIL reset_lerr got %b exp 0", o_len_err); end
        rst_n = 1'b1;
        tick(6);
    endtask

    task automatic test_a5;
        int lat;
        res_t got, exp;
        cap_q.delete();
        frame_open(4'd8);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL a5_busy got %b exp 1", o_busy); end
        send_bits(64'hA5, 8);
        frame = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (o_valid && lat == 0) lat = k;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL a5_latency got %0d exp 3", lat); end
        checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL a5_pulses got %0d exp 1", cap_q.size()); end
        exp = res_t'({32'h000000A5, 6'd8, 1'b0, 1'b0});
        if (cap_q.size() > 0) begin
            got = cap_q.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL a5_result got %h exp %h", got, exp); end
        end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL a5_busy_end got %b exp 0", o_busy); end
        tick(20);
        checks++; if (o_data !== 32'hA5 || o_bit_count !== 6'd8) begin
            errors++; $display("FAIL a5_hold got %h/%0d exp a5/8", o_data, o_bit_count);
        end
    endtask

    task automatic test_overflow;
        res_t got, exp;
        logic [63:0] v;
        cap_q.delete();
        v = (64'd1 << 34) - 64'd1;
        exp = model(v, 34, 4'd0);
        frame_open(4'd0);
        send_bits(v, 34);
        frame = 1'b0;
        wait_cap(1, 20);
        checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL ovf_pulses got %0d exp 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            got = cap_q.pop_front();
            checks++; if (got.data !== 32'hFFFFFFFF || got.cnt !== 6'd32 || got.ovf !== 1'b1) begin
                errors++; $display("FAIL ovf_fields got %h/%0d/%b exp ffffffff/32/1", got.data, got.cnt, got.ovf);
            end
            checks++; if (got !== exp) begin errors++; $display("FAIL ovf_model got %h exp %h", got, exp); end
        end
    endtask

    task automatic test_random;
        res_t got, exp;
        logic [63:0] v;
        int n;
        logic [3:0] len;
        for (int f = 0; f < 10; f++) begin
            cap_q.delete();
            n   = int'($urandom_range(1, 40));
            v   = {$urandom, $urandom};
            len = 4'($urandom_range(0, 15));
            exp = model(v, n, len);
            frame_open(len);
            send_bits(v, n);
            frame = 1'b0;
            wait_cap(1, 20);
            checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL rand%0d_pulses got %0d exp 1", f, cap_q.size()); end
            if (cap_q.size() > 0) begin
                got = cap_q.pop_front();
                checks++; if (got !== exp) begin errors++; $display("FAIL rand%0d n=%0d got %h exp %h", f, n, got, exp); end
            end
        end
    endtask

    task automatic test_empty;
        logic [DW-1:0] held;
        cap_q.delete();
        held = o_data;
        frame = 1'b1;
        tick(3);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL empty_busy_on got %b exp 1", o_busy); end
        tick(10);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL empty_busy_mid got %b exp 1", o_busy); end
        frame = 1'b0;
        tick(4);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL empty_busy_off got %b exp 0", o_busy); end
        tick(6);
        checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL empty_pulses got %0d exp 0", cap_q.size()); end
        checks++; if (o_data !== held) begin errors++; $display("FAIL empty_hold got %h exp %h", o_data, held); end
    endtask

    task automatic test_reset_midframe;
        res_t got, exp;
        cap_q.delete();
        frame_open(4'd4);
        send_bits(64'h16, 5);
        rst_n = 1'b0;
        #1;
        checks++; if ({o_data, o_bit_count, o_valid, o_busy, o_overflow, o_len_err} !== '0) begin
            errors++; $display("FAIL midrst_outputs got %h/%0d/%b%b%b%b exp all 0",
                o_data, o_bit_count, o_valid, o_busy, o_overflow, o_len_err);
        end
        tick(2);
        rst_n = 1'b1;
        tick(10);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", o_busy); end
        frame = 1'b0;
        tick(6);
        checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL midrst_pulses got %0d exp 0", cap_q.size()); end
        exp = model(64'h9, 4, 4'd4);
        frame_open(4'd4);
        send_bits(64'h9, 4);
        frame = 1'b0;
        wait_cap(1, 20);
        checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL midrst_next_pulses got %0d exp 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            got = cap_q.pop_front();
            checks++; if (got.data !== 32'h9 || got.cnt !== 6'd4 || got !== exp) begin
                errors++; $display("FAIL midrst_next got %h exp %h", got, exp);
            end
        end
    endtask

    task automatic test_len_check;
        res_t got;
        logic exp_a, exp_b;
`ifdef SPI_RX_LEN_CHECK_EN
        exp_a = 1'b1;
`else
        exp_a = 1'b0;
`endif
        exp_b = 1'b0;
        cap_q.delete();
        frame_open(4'd6);
        send_bits(64'h15, 5);
        frame = 1'b0;
        wait_cap(1, 20);
        checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL len6_pulses got %0d exp 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            got = cap_q.pop_front();
            checks++; if (got.lerr !== exp_a) begin errors++; $display("FAIL len6_lerr got %b exp %b", got.lerr, exp_a); end
        end
        frame_open(4'd0);
        send_bits(64'h1, 1);
        frame = 1'b0;
        wait_cap(1, 20);
        checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL len0_pulses got %0d exp 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            got = cap_q.pop_front();
            checks++; if (got.lerr !== exp_b || got.cnt !== 6'd1) begin
                errors++; $display("FAIL len0_lerr got %b/%0d exp %b/1", got.lerr, got.cnt, exp_b);
            end
        end
    endtask

    task automatic test_back_to_back;
        res_t got, exp1, exp2;
        logic [63:0] v1, v2;
        cap_q.delete();
        v1 = 64'({$urandom} & 32'hFF);
        v2 = 64'({$urandom} & 32'hFFF);
        exp1 = model(v1, 8, 4'd8);
        exp2 = model(v2, 12, 4'd8);
        frame_open(4'd8);
        send_bits(v1, 8);
        frame = 1'b0;
        tick(1);
        frame = 1'b1;
        tick(2);
        // Reopened frame is synchronized exactly while the first result is presented.
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_overlap got %b exp 1", o_valid); end
        tick(3);
        send_bits(v2, 12);
        frame = 1'b0;
        wait_cap(2, 30);
        checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", cap_q.size()); end
        if (cap_q.size() > 1) begin
            got = cap_q.pop_front();
            checks++; if (got !== exp1) begin errors++; $display("FAIL b2b_first got %h exp %h", got, exp1); end
            got = cap_q.pop_front();
            checks++; if (got !== exp2) begin errors++; $display("FAIL b2b_second got %h exp %h", got, exp2); end
        end
        tick(5);
    endtask

    initial begin
        test_reset();
        test_a5();
        test_overflow();
        test_random();
        test_empty();
        test_reset_midframe();
        test_len_check();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
